// File: rtl/testchk_pkg.sv
// -----------------------------------------------------------------------------
// testchk_pkg
// Shared constants for the frame-buffer pattern checker:
//   - FSM state encoding (UNLOCKED / ACQUIRE / LOCKED)
//   - default values for SAMPLE_PHASE, LOCK_COUNT and ERR_W
//   - consecutive-mismatch threshold used when TESTCHK_RESYNC_EN is defined
//   - modulo-8 increment helper
// -----------------------------------------------------------------------------
package testchk_pkg;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [2:0]  SAMPLE_PHASE_DEF = 3'b110;
  localparam int unsigned LOCK_COUNT_DEF   = 32'd4;
  localparam int unsigned ERR_W_DEF        = 32'd16;

  // Consecutive LOCKED mismatches that force a return to UNLOCKED.
  localparam logic [1:0] RESYNC_THRESH = 2'd3;

  // The test pattern counts modulo 8, so 7 + 1 wraps to 0.
  function automatic logic [2:0] inc3(input logic [2:0] v);
    return v + 3'd1;
  endfunction

endpackage

// File: rtl/testchk_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. A clear that coincides with
// an increment yields 1, so the event seen in the clearing cycle is kept.
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous active-high reset (count -> 0)
//   inc   in  count one event
//   clr   in  synchronous clear
//   count out registered count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 32'd16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, otherwise increment unless saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? ONE : '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/testchk.sv
// -----------------------------------------------------------------------------
// testchk
// Checks that a 3-bit incrementing pattern read back from a frame buffer stays
// in sequence. Samples are taken when clkPhase == SAMPLE_PHASE and sample_en
// is high. After LOCK_COUNT consecutive in-sequence samples the checker locks;
// while locked every mismatch pulses err_pulse and bumps a saturating counter,
// then the expected value resynchronises to the received one.
//
// Optional feature: define TESTCHK_RESYNC_EN to drop back to UNLOCKED after
// three consecutive locked mismatches. Without it, only reset leaves LOCKED.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   clkPhase   in   [2:0] current 8-phase clock phase
//   sample_en  in   sample qualifier
//   data_in    in   [2:0] value read back from the frame buffer
//   clr_count  in   synchronous clear of err_count
//   locked     out  high while in LOCKED (registered)
//   err_pulse  out  one-cycle strobe per locked mismatch (registered)
//   err_count  out  [ERR_W-1:0] saturating mismatch count (registered)
// -----------------------------------------------------------------------------
module testchk
  import testchk_pkg::*;
#(
  parameter logic [2:0]  SAMPLE_PHASE = SAMPLE_PHASE_DEF,
  parameter int unsigned LOCK_COUNT   = LOCK_COUNT_DEF,
  parameter int unsigned ERR_W        = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       clkPhase,
  input  logic             sample_en,
  input  logic [2:0]       data_in,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] LOCK_RUN = LOCK_COUNT[3:0];

  logic [1:0] state_q, state_d;
  logic [2:0] exp_q,   exp_d;
  logic [2:0] prev_q,  prev_d;
  logic [3:0] run_q,   run_d;
  logic       locked_q;
  logic       err_pulse_q;
  logic       sample_s;
  logic       mismatch_s;
`ifdef TESTCHK_RESYNC_EN
  logic [1:0] mis_q, mis_d;
`endif

  assign sample_s = (clkPhase == SAMPLE_PHASE) && sample_en;

  // FSM next state and pattern tracking; only a sample event moves anything.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    prev_d     = prev_q;
    run_d      = run_q;
    mismatch_s = 1'b0;
`ifdef TESTCHK_RESYNC_EN
    mis_d      = mis_q;
`endif
    if (sample_s) begin
      case (state_q)
        ST_UNLOCKED: begin
          prev_d  = data_in;
          run_d   = 4'd1;
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          prev_d = data_in;
          if (data_in == inc3(prev_q)) begin
            run_d = run_q + 4'd1;
            if ((run_q + 4'd1) == LOCK_RUN) begin
              state_d = ST_LOCKED;
              exp_d   = inc3(data_in);
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            // Broken sequence: the current sample starts a new run.
            run_d = 4'd1;
          end
        end
        ST_LOCKED: begin
          if (data_in == exp_q) begin
            exp_d = inc3(exp_q);
`ifdef TESTCHK_RESYNC_EN
            mis_d = 2'd0;
`endif
          end else begin
            mismatch_s = 1'b1;
            exp_d      = inc3(data_in);
`ifdef TESTCHK_RESYNC_EN
            if (mis_q == (RESYNC_THRESH - 2'd1)) begin
              state_d = ST_UNLOCKED;
              mis_d   = 2'd0;
            end else begin
              mis_d   = mis_q + 2'd1;
            end
`endif
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_UNLOCKED;
      exp_q       <= 3'd0;
      prev_q      <= 3'd0;
      run_q       <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      locked_q    <= (state_d == ST_LOCKED);
      err_pulse_q <= mismatch_s;
    end
  end

`ifdef TESTCHK_RESYNC_EN
  // Consecutive locked-mismatch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 2'd0;
    end else begin
      mis_q <= mis_d;
    end
  end
`endif

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch_s),
    .clr   (clr_count),
    .count (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_testchk.sv
// -----------------------------------------------------------------------------
// tb_testchk
// Directed self-checking bench for testchk (default parameters). Inputs change
// 1 time unit after the rising edge; outputs are checked at that same point,
// i.e. they show the effect of the sample taken at the preceding edge.
// -----------------------------------------------------------------------------
module tb_testchk;

  localparam logic [2:0] SP = 3'b110;

  logic        clk;
  logic        reset;
  logic [2:0]  clkPhase;
  logic        sample_en;
  logic [2:0]  data_in;
  logic        clr_count;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  testchk dut (
    .clk       (clk),
    .reset     (reset),
    .clkPhase  (clkPhase),
    .sample_en (sample_en),
    .data_in   (data_in),
    .clr_count (clr_count),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One qualified sample of value d, then inputs return to idle.
  task automatic smp(input logic [2:0] d);
    data_in   = d;
    sample_en = 1'b1;
    clkPhase  = SP;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    clkPhase  = 3'd0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    clkPhase  = 3'd0;
    sample_en = 1'b0;
    data_in   = 3'd0;
    clr_count = 1'b0;
    idle();
    idle();
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_pulse",  {31'd0, err_pulse}, 32'd0);
    chk("rst_count",  {16'd0, err_count}, 32'd0);
    reset = 1'b0;
    idle();

    // Acquire with wrap 7 -> 0.
    smp(3'd5); smp(3'd6); smp(3'd7);
    chk("acq_not_yet", {31'd0, locked}, 32'd0);
    smp(3'd0);
    chk("lock_after4", {31'd0, locked}, 32'd1);
    chk("lock_count0", {16'd0, err_count}, 32'd0);

    // Locked: 1,2 match, 4 mismatches (expected 3), 5 matches.
    smp(3'd1);
    chk("match1_pulse", {31'd0, err_pulse}, 32'd0);
    smp(3'd2);
    smp(3'd4);
    chk("mis_pulse", {31'd0, err_pulse}, 32'd1);
    chk("mis_count", {16'd0, err_count}, 32'd1);
    idle();
    chk("pulse_one_cycle", {31'd0, err_pulse}, 32'd0);
    smp(3'd5);
    chk("resync_pulse", {31'd0, err_pulse}, 32'd0);
    chk("resync_count", {16'd0, err_count}, 32'd1);

    // Non-events: sample_en low at the sample phase, wrong phase with enable.
    data_in = 3'd0; clkPhase = SP; sample_en = 1'b0;
    idle();
    chk("en_low_pulse", {31'd0, err_pulse}, 32'd0);
    data_in = 3'd0; clkPhase = 3'd5; sample_en = 1'b1;
    idle();
    sample_en = 1'b0; clkPhase = 3'd0;
    chk("bad_phase_count", {16'd0, err_count}, 32'd1);
    smp(3'd6);  // expected is still 6
    chk("exp_held", {31'd0, err_pulse}, 32'd0);

    // Bring count to 9 with isolated mismatches (0 then matching 1).
    for (int i = 0; i < 8; i++) begin
      smp(3'd0);
      smp(3'd1);
    end
    chk("count9", {16'd0, err_count}, 32'd9);
    clr_count = 1'b1;
    smp(3'd0);  // expected 2: mismatch coincident with clear
    clr_count = 1'b0;
    chk("clr_mis_count", {16'd0, err_count}, 32'd1);
    chk("clr_mis_pulse", {31'd0, err_pulse}, 32'd1);
    clr_count = 1'b1;
    idle();
    clr_count = 1'b0;
    chk("clr_only", {16'd0, err_count}, 32'd0);

    // Three consecutive locked mismatches (expected is 1).
    smp(3'd1);
    smp(3'd0);
    smp(3'd0);
    chk("mis2_locked", {31'd0, locked}, 32'd1);
    smp(3'd0);
    chk("mis3_count", {16'd0, err_count}, 32'd3);
    chk("mis3_pulse", {31'd0, err_pulse}, 32'd1);
`ifdef TESTCHK_RESYNC_EN
    chk("mis3_locked", {31'd0, locked}, 32'd0);
`else
    chk("mis3_locked", {31'd0, locked}, 32'd1);
`endif

    // Asynchronous reset while locked.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_locked", {31'd0, locked}, 32'd0);
    chk("async_rst_count",  {16'd0, err_count}, 32'd0);
    idle();
    reset = 1'b0;
    idle();

    // Reset mid-acquire after 3 good samples discards the run.
    smp(3'd2); smp(3'd3); smp(3'd4);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    idle();
    smp(3'd5);
    chk("reacq_1", {31'd0, locked}, 32'd0);
    smp(3'd6); smp(3'd7);
    chk("reacq_3", {31'd0, locked}, 32'd0);
    smp(3'd0);
    chk("reacq_4", {31'd0, locked}, 32'd1);

`ifndef TESTCHK_RESYNC_EN
    // Saturation: 65535 mismatches (constant 3 never equals expected 4).
    for (int i = 0; i < 65535; i++) begin
      smp(3'd3);
    end
    chk("sat_full", {16'd0, err_count}, 32'h0000FFFF);
    smp(3'd3);
    chk("sat_hold",  {16'd0, err_count}, 32'h0000FFFF);
    chk("sat_pulse", {31'd0, err_pulse}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
